// File: rtl/bcd2_pkg.sv
// bcd2_pkg: shared types and constants for the bcd2 decode path (build option BCD2BIN_ERR_EN)
package bcd2_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd2_state_e;
  localparam int BCD2BIN_NSHIFT = 7;
  localparam int BCD_DIGIT_MAX = 9;
  localparam int BCD2_W = 8;
  localparam int BIN2_W = 7;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: reverse double-dabble digit correction, subtract 3 from digits of 8 or more
module bcd_digit_adj (
  input  logic [3:0] in,
  output logic [3:0] out
);
  assign out = (in >= 4'd8) ? in - 4'd3 : in;
endmodule

// File: rtl/bcd2_to_bin.sv
// bcd2_to_bin: iterative two-digit BCD to 7-bit binary converter; BCD2BIN_ERR_EN enables invalid-digit rejection
module bcd2_to_bin
  import bcd2_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BCD2_W-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic [BIN2_W-1:0] bin_out,
  output logic              err
);
  localparam int WORK_W = BCD2_W + BIN2_W;
  bcd2_state_e       state_q, state_d;
  logic [WORK_W-1:0] work_q, work_d, shifted;
  logic [2:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [BIN2_W-1:0] bin_q, bin_d;
  logic [3:0]        adj_t, adj_o;
  logic              accept, bad;
  assign shifted = work_q >> 1;
  bcd_digit_adj u_adj_tens (.in(shifted[WORK_W-1 -: 4]), .out(adj_t));
  bcd_digit_adj u_adj_ones (.in(shifted[BIN2_W +: 4]), .out(adj_o));
  // next-state: accept/reject requests, run one shift per cycle, publish result after the last one
  always_comb begin
    accept  = start && (state_q != SHIFT);
`ifdef BCD2BIN_ERR_EN
    bad     = accept && ((bcd_in[7:4] > 4'(BCD_DIGIT_MAX)) || (bcd_in[3:0] > 4'(BCD_DIGIT_MAX)));
`else
    bad     = 1'b0;
`endif
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
    err_d   = 1'b0;
    if (bad) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (accept) begin
      state_d = SHIFT;
      work_d  = {bcd_in, {BIN2_W{1'b0}}};
      cnt_d   = 3'd0;
      busy_d  = 1'b1;
    end else if (state_q == SHIFT) begin
      work_d = {adj_t, adj_o, shifted[BIN2_W-1:0]};
      cnt_d  = cnt_q + 3'd1;
      if (cnt_q == 3'(BCD2BIN_NSHIFT - 1)) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        bin_d   = shifted[BIN2_W-1:0];
      end
    end else begin
      state_d = IDLE;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_q;
  assign err     = err_q;
endmodule

// File: tb/tb_bcd2_to_bin.sv
// tb_bcd2_to_bin: directed and random checks of bcd2_to_bin against a timeline model
module tb_bcd2_to_bin;
`ifdef BCD2BIN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] bcd_in = 8'h00;
  logic       busy, done, err;
  logic [6:0] bin_out;
  int         vectors = 0, miscompares = 0;
  bit         chk_en = 1'b0;
  int         rem = 0, pend = 0, m_bin = 0;
  bit         m_busy = 0, m_done = 0, m_err = 0;

  bcd2_to_bin dut (.clk(clk), .reset(reset), .start(start), .bcd_in(bcd_in),
                   .busy(busy), .done(done), .bin_out(bin_out), .err(err));

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference timeline: a request occupies 7 cycles and then yields 10*tens+ones
  always @(posedge clk) begin
    m_err = 1'b0;
    if (reset) begin
      rem = 0; m_busy = 0; m_done = 0; m_bin = 0;
    end else if (rem > 0) begin
      rem--;
      m_done = 0;
      if (rem == 0) begin m_busy = 0; m_done = 1; m_bin = pend; end
    end else begin
      m_done = 0;
      if (start) begin
        if (ERR_EN && (bcd_in[7:4] > 9 || bcd_in[3:0] > 9)) m_err = 1;
        else begin rem = 7; pend = 10 * bcd_in[7:4] + bcd_in[3:0]; m_busy = 1; end
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    cmp("busy", {7'd0, busy}, {7'd0, m_busy});
    cmp("done", {7'd0, done}, {7'd0, m_done});
    cmp("bin_out", {1'b0, bin_out}, 8'(m_bin));
    cmp("err", {7'd0, err}, {7'd0, m_err});
    cmp("busy_and_done", {7'd0, busy & done}, 8'd0);
  end

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (done !== 1'b1) cmp("done_timeout", {7'd0, done}, 8'd1);
  endtask

  task automatic convert(input logic [7:0] v, input int exp);
    int n;
    start = 1'b1; bcd_in = v;
    @(negedge clk);
    start = 1'b0; bcd_in = $urandom_range(0, 255);
    wait_done(n);
    cmp("latency", 8'(n), 8'd7);
    cmp("result", {1'b0, bin_out}, 8'(exp));
  endtask

  initial begin
    int n, n2, extra;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    cmp("reset_bin", {1'b0, bin_out}, 8'd0);
    convert(8'h42, 42);
    cmp("busy_in_done", {7'd0, busy}, 8'd0);
    for (int t = 0; t < 10; t++)
      for (int o = 0; o < 10; o++) begin
        convert({4'(t), 4'(o)}, 10 * t + o);
        @(negedge clk);
      end
    convert(8'h99, 99);
    convert(8'h00, 0);
    // second request during busy is ignored
    start = 1'b1; bcd_in = 8'h57;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; bcd_in = 8'h12;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    cmp("ignore_result", {1'b0, bin_out}, 8'd57);
    extra = 0;
    repeat (10) begin @(negedge clk); extra += done; end
    cmp("ignore_extra_done", 8'(extra), 8'd0);
    // reset during conversion aborts it
    start = 1'b1; bcd_in = 8'h31;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cmp("abort_busy", {7'd0, busy}, 8'd0);
    cmp("abort_bin", {1'b0, bin_out}, 8'd0);
    extra = 0;
    repeat (10) begin @(negedge clk); extra += done; end
    cmp("abort_no_done", 8'(extra), 8'd0);
    convert(8'h08, 8);
    @(negedge clk);
    // back-to-back with start held through DONE
    start = 1'b1; bcd_in = 8'h10;
    @(negedge clk);
    bcd_in = 8'h77;
    wait_done(n);
    cmp("b2b_first", {1'b0, bin_out}, 8'd10);
    @(negedge clk);
    start = 1'b0;
    cmp("b2b_busy", {7'd0, busy}, 8'd1);
    wait_done(n2);
    cmp("b2b_gap", 8'(n2 + 1), 8'd8);
    cmp("b2b_second", {1'b0, bin_out}, 8'd77);
    @(negedge clk);
    if (ERR_EN) begin
      convert(8'h25, 25);
      @(negedge clk);
      start = 1'b1; bcd_in = 8'h3A;
      @(negedge clk);
      start = 1'b0;
      cmp("err_pulse", {7'd0, err}, 8'd1);
      cmp("err_bin", {1'b0, bin_out}, 8'd25);
      @(negedge clk);
    end
    // random traffic, occasional resets
    repeat (3000) begin
      reset  = ($urandom_range(0, 99) == 0);
      start  = ($urandom_range(0, 3) != 0);
      bcd_in = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if (ERR_EN && $urandom_range(0, 15) == 0) bcd_in[3:0] = 4'($urandom_range(10, 15));
      @(negedge clk);
    end
    reset = 1'b0; start = 1'b0;
    repeat (10) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bcd2_to_bin.md
# bcd2_to_bin

Sequential converter from two-digit packed BCD (00–99) to 7-bit binary. It is the decode side of the `bcd2` counter. It takes the counter's 8-bit BCD output and recovers the binary count for arithmetic and compare logic downstream. Conversion is iterative (reverse double-dabble), one shift per clock, with a start/busy/done handshake.

## Interface
- No parameters; the width is fixed at two BCD digits and a 7-bit result.
- `clk`  input  1  single clock; all state changes on the rising edge
- `reset`  input  1  synchronous, active-high reset
- `start`  input  1  request a conversion of `bcd_in`; sampled only in IDLE or DONE
- `bcd_in`  input  8  packed BCD: `[7:4]` is tens, `[3:0]` is ones; sampled in the same cycle as `start`
- `busy`  output  1  a conversion is in progress
- `done`  output  1  one-cycle pulse: `bin_out` has just been updated
- `bin_out`  output  7  binary result, held until the next successful conversion
- `err`  output  1  one-cycle pulse: a request was rejected for an invalid digit (only with `BCD2BIN_ERR_EN`)

## Operation
- States: IDLE, SHIFT, DONE.
- Reset values: state IDLE, `busy` 0, `done` 0, `bin_out` 0, `err` 0, iteration count 0.
- Working register: 15 bits, arranged as `{bcd[7:0], bin[6:0]}`.
- IDLE or DONE with `start`=1 (and the digits valid):
  - load `{bcd_in, 7'b0}`
  - clear the iteration count
  - go to SHIFT
- SHIFT, one iteration per cycle:
  - shift the working register right by 1
  - then, for each BCD digit: if the digit ≥ 8, subtract 3 (4-bit result, no carry out)
- After the 7th iteration:
  - write `bin` into `bin_out`
  - go to DONE
- DONE lasts one cycle, then IDLE, unless `start` is asserted, which starts a new conversion directly.
- `start` during SHIFT is ignored; no queueing.
- `bcd_in` is don't-care in every cycle except the cycle in which `start` is accepted.
- Reset mid-conversion: abort at that edge and restore all reset values. No `done` is produced; `bin_out` is 0.
- Result: `bin_out` = 10·tens + ones, in the range 0–99. It never exceeds 7 bits.

## Timing
- `start` accepted at edge k:
  - `busy` = 1 from k+1 through k+7 (7 cycles)
  - iterations happen at edges k+1 … k+7
  - `bin_out` is valid and `done` = 1 after edge k+7, for one cycle only
- Latency from `start` to `done` is 7 cycles.
- Back-to-back: `start` held high in the DONE cycle is accepted at edge k+8. `done` then drops and `busy` rises at k+8, giving a throughput of one result per 8 cycles.
- `busy` and `done` are never high at the same time.
- `done` always implies that `bin_out` changed at that same edge.

## Configuration
- Macro: `BCD2BIN_ERR_EN`.
- Defined:
  - in IDLE or DONE, `start` with either nibble > 9 is rejected
  - `err` = 1 for one cycle after that edge
  - state goes to IDLE; `busy`, `done` and `bin_out` are unchanged
  - the rejecting logic adds no latency to valid requests
- Undefined:
  - `err` is tied to 0 and no check is made
  - invalid digits are converted with no check; the resulting `bin_out` is don't-care and is not checked by the bench

## Structure
- Package `bcd2_pkg`:
  - state enum (IDLE/SHIFT/DONE)
  - `BCD2BIN_NSHIFT` = 7
  - `BCD_DIGIT_MAX` = 9
  - `BCD2_W` = 8
  - `BIN2_W` = 7
- Sub-module `bcd_digit_adj`: 4-bit combinational, `out = (in >= 8) ? in - 3 : in`. It is instantiated twice, once for tens and once for ones.

## Test plan
- Reset 2 cycles, then `bcd_in`=8'h42 with `start` for 1 cycle -> `busy` for 7 cycles, then `done` pulse with `bin_out`=7'd42, and `busy`=0 in the `done` cycle.
- Sweep `bcd_in` 8'h00 … 8'h99 (valid codes only), one conversion each -> `bin_out` = 10·tens + ones every time; 8'h99 -> 99 and 8'h00 -> 0.
- `start` with 8'h57, then pulse `start` with 8'h12 at cycle 3 of `busy` -> a single `done`, `bin_out`=57; the second request is ignored.
- Convert 8'h31, then assert `reset` at the 4th `busy` cycle -> no `done`; `busy`=0 and `bin_out`=0 on the next edge; a following 8'h08 request -> `bin_out`=8.
- `start` held high across DONE with 8'h10 then 8'h77 -> `done` pulses 8 cycles apart, with `bin_out` 10 then 77.
- With `BCD2BIN_ERR_EN`: after a prior result of 25, `start` with 8'h3A -> `err` pulse 1 cycle, no `busy`, no `done`, `bin_out` stays 25.
